// File: rtl/stream_crossbar_pkg.sv
// stream_crossbar_pkg: shared helpers for the stream crossbar
package stream_crossbar_pkg;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_crossbar_if.sv
// stream_crossbar_if: packed valid/ready input and output streams of the crossbar
interface stream_crossbar_if import stream_crossbar_pkg::*; #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4,
  parameter int WIDTH   = 32
) ();
  localparam int DEST_W = clog2_min1(NUM_OUT);
  localparam int SRC_W  = clog2_min1(NUM_IN);
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN*WIDTH-1:0]   in_data;
  logic [NUM_IN*DEST_W-1:0]  in_dest;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT*WIDTH-1:0]  out_data;
  logic [NUM_OUT*SRC_W-1:0]  out_src;
  logic [NUM_OUT-1:0]        out_ready;
  logic                      err_bad_dest;
  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data, out_src, err_bad_dest
  );
  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, out_src, err_bad_dest
  );
endinterface

// File: rtl/stream_crossbar_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr_i
module rr_arbiter import stream_crossbar_pkg::*; #(
  parameter int N = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);
  logic [IW-1:0] idx;
  // scan from the farthest offset down so the nearest request wins last
  always_comb begin
    grant_idx_o = '0;
    any_o = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        grant_idx_o = idx;
        any_o = 1'b1;
      end
    end
    grant_o = any_o ? N'(1) << grant_idx_o : '0;
  end
endmodule

// File: rtl/stream_crossbar.sv
// stream_crossbar: NUM_IN x NUM_OUT valid/ready switch with per-output round-robin and a registered output stage
module stream_crossbar import stream_crossbar_pkg::*; #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4,
  parameter int WIDTH   = 32,
  localparam int DEST_W = clog2_min1(NUM_OUT),
  localparam int SRC_W  = clog2_min1(NUM_IN)
) (
  input logic clk,
  input logic rst,
  stream_crossbar_if.slave bus
);
  logic [NUM_IN-1:0][WIDTH-1:0]   in_data;
  logic [NUM_IN-1:0][DEST_W-1:0]  in_dest;
  logic [NUM_IN-1:0]              bad, in_ready;
  logic [NUM_IN-1:0]              req [NUM_OUT];
  logic [NUM_IN-1:0]              gnt [NUM_OUT];
  logic [SRC_W-1:0]               gidx [NUM_OUT];
  logic [NUM_OUT-1:0]             any, load_en;
  logic [NUM_OUT-1:0]             out_valid_q, out_valid_d;
  logic [NUM_OUT-1:0][WIDTH-1:0]  out_data_q, out_data_d;
  logic [NUM_OUT-1:0][SRC_W-1:0]  out_src_q, out_src_d, ptr_q, ptr_d;
  logic                           err_q, err_d;
  assign in_data          = bus.in_data;
  assign in_dest          = bus.in_dest;
  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_src      = out_src_q;
  assign bus.err_bad_dest = err_q;
  // requests are masked by load_en so a stalled output never grants
  always_comb begin
    for (int i = 0; i < NUM_IN; i++)
      bad[i] = bus.in_valid[i] && ({1'b0, in_dest[i]} >= (DEST_W+1)'(NUM_OUT));
    for (int j = 0; j < NUM_OUT; j++) begin
      load_en[j] = !out_valid_q[j] || bus.out_ready[j];
      for (int i = 0; i < NUM_IN; i++)
        req[j][i] = load_en[j] && bus.in_valid[i] && (in_dest[i] == DEST_W'(j));
    end
  end
  for (genvar j = 0; j < NUM_OUT; j++) begin : g_arb
    rr_arbiter #(.N(NUM_IN)) u_arb (
      .req_i      (req[j]),
      .ptr_i      (ptr_q[j]),
      .grant_o    (gnt[j]),
      .grant_idx_o(gidx[j]),
      .any_o      (any[j])
    );
  end
  // bad-destination beats are accepted and dropped
  always_comb begin
    in_ready = bad;
    err_d = |bad;
    for (int j = 0; j < NUM_OUT; j++) begin
      in_ready = in_ready | gnt[j];
      out_valid_d[j] = load_en[j] ? any[j] : out_valid_q[j];
      out_data_d[j] = (load_en[j] && any[j]) ? in_data[gidx[j]] : out_data_q[j];
      out_src_d[j] = (load_en[j] && any[j]) ? gidx[j] : out_src_q[j];
      ptr_d[j] = (load_en[j] && any[j]) ? ((gidx[j] == SRC_W'(NUM_IN - 1)) ? '0 : gidx[j] + 1'b1) : ptr_q[j];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_stream_crossbar.sv
// tb_stream_crossbar: directed scenarios plus randomized traffic against a round-robin reference model
module tb_stream_crossbar;
  localparam int NI = 4, NO = 4, W = 8, DW = 2, SW = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stream_crossbar_if #(.NUM_IN(NI), .NUM_OUT(NO), .WIDTH(W)) a ();
  stream_crossbar_if #(.NUM_IN(NI), .NUM_OUT(3), .WIDTH(W)) b ();
  stream_crossbar #(.NUM_IN(NI), .NUM_OUT(NO), .WIDTH(W)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  stream_crossbar #(.NUM_IN(NI), .NUM_OUT(3), .WIDTH(W)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  // reference model of dut_a: output registers, pointers and this cycle's grants
  bit mv [NO];
  int md [NO], ms [NO], mp [NO], gr [NO], gd [NO];
  bit ld [NO];
  logic [NI-1:0] exp_rdy;

  function automatic void model_reset();
    for (int j = 0; j < NO; j++) begin
      mv[j] = 0; md[j] = 0; ms[j] = 0; mp[j] = 0;
    end
  endfunction

  function automatic void model_eval();
    int i;
    exp_rdy = '0;
    for (int j = 0; j < NO; j++) begin
      ld[j] = !mv[j] || a.out_ready[j];
      gr[j] = -1;
      gd[j] = 0;
      if (ld[j])
        for (int k = 0; k < NI; k++) begin
          i = (mp[j] + k) % NI;
          if (gr[j] < 0 && a.in_valid[i] && int'(a.in_dest[i*DW +: DW]) == j) begin
            gr[j] = i;
            gd[j] = int'(a.in_data[i*W +: W]);
          end
        end
      if (gr[j] >= 0) exp_rdy[gr[j]] = 1'b1;
    end
  endfunction

  function automatic void model_clock();
    for (int j = 0; j < NO; j++)
      if (ld[j]) begin
        mv[j] = gr[j] >= 0;
        if (gr[j] >= 0) begin
          md[j] = gd[j]; ms[j] = gr[j]; mp[j] = (gr[j] + 1) % NI;
        end
      end
  endfunction

  task automatic cycle();
    model_eval();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic drive(input int i, input bit v, input int d, input int dst);
    a.in_valid[i] = v;
    a.in_data[i*W +: W] = W'(d);
    a.in_dest[i*DW +: DW] = DW'(dst);
  endtask

  task automatic idle();
    a.in_valid = '0; a.in_data = '0; a.in_dest = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    a.out_ready = '0;
    b.in_valid = '0; b.in_data = '0; b.in_dest = '0; b.out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (a.out_valid !== '0 || a.out_data !== '0 || a.out_src !== '0 || a.err_bad_dest !== 1'b0) begin
      errors++;
      $display("FAIL reset_a valid=%b data=%h src=%h err=%b required all zero", a.out_valid, a.out_data, a.out_src, a.err_bad_dest);
    end
    checks++;
    if (b.out_valid !== '0 || b.out_data !== '0 || b.out_src !== '0 || b.err_bad_dest !== 1'b0) begin
      errors++;
      $display("FAIL reset_b valid=%b data=%h src=%h err=%b required all zero", b.out_valid, b.out_data, b.out_src, b.err_bad_dest);
    end
  endtask

  task automatic test_single();
    a.out_ready = '1;
    drive(2, 1, 'hA5, 1);
    #1;
    checks++;
    if (a.in_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got=%b want=0100", a.in_ready);
    end
    cycle();
    idle();
    checks++;
    if (a.out_valid !== 4'b0010 || a.out_data[15:8] !== 8'hA5 || a.out_src[3:2] !== 2'd2) begin
      errors++;
      $display("FAIL single_out valid=%b data1=%h src1=%0d want 0010/a5/2", a.out_valid, a.out_data[15:8], a.out_src[3:2]);
    end
    cycle();
    checks++;
    if (a.out_valid !== 4'b0000) begin
      errors++; $display("FAIL single_drain valid=%b want 0000", a.out_valid);
    end
  endtask

  task automatic test_parallel();
    for (int i = 0; i < NI; i++) drive(i, 1, 'h10 + i, 3 - i);
    #1;
    checks++;
    if (a.in_ready !== 4'hF) begin
      errors++; $display("FAIL parallel_ready got=%b want=1111", a.in_ready);
    end
    cycle();
    idle();
    checks++;
    if (a.out_valid !== 4'hF || a.out_data !== 32'h10111213 || a.out_src !== 8'h1B) begin
      errors++;
      $display("FAIL parallel_out valid=%b data=%h src=%h want f/10111213/1b", a.out_valid, a.out_data, a.out_src);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    logic [7:0] ed;
    logic [NI-1:0] er;
    a.out_ready = '1;
    for (int i = 0; i < NI; i++) drive(i, 1, 'h20 + i, 0);
    #1;
    for (int k = 0; k < 6; k++) begin
      er = NI'(1) << (k % NI);
      ed = 8'(32'h20 + k % NI);
      checks++;
      if (a.in_ready !== er) begin
        errors++; $display("FAIL rr_ready[%0d] got=%b want=%b", k, a.in_ready, er);
      end
      cycle();
      checks++;
      if (a.out_valid !== 4'b0001 || a.out_src[1:0] !== SW'(k % NI) || a.out_data[7:0] !== ed) begin
        errors++;
        $display("FAIL rr_out[%0d] valid=%b src0=%0d data0=%h want 0001/%0d/%h", k, a.out_valid, a.out_src[1:0], a.out_data[7:0], k % NI, ed);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_backpressure();
    a.out_ready = '1;
    drive(0, 1, 'h55, 1);
    cycle();
    idle();
    a.out_ready[1] = 1'b0;
    drive(3, 1, 'h66, 1);
    drive(2, 1, 'h44, 2);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (a.in_ready[3] !== 1'b0 || a.in_ready[2] !== 1'b1) begin
        errors++; $display("FAIL bp_ready[%0d] got=%b want x1x0 on inputs 3..2", k, a.in_ready);
      end
      cycle();
      checks++;
      if (a.out_valid[1] !== 1'b1 || a.out_data[15:8] !== 8'h55 || a.out_src[3:2] !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid1=%b data1=%h src1=%0d want 1/55/0", k, a.out_valid[1], a.out_data[15:8], a.out_src[3:2]);
      end
    end
    a.out_ready[1] = 1'b1;
    #1;
    checks++;
    if (a.in_ready[3] !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready got=%b want 1", a.in_ready[3]);
    end
    cycle();
    idle();
    checks++;
    if (a.out_valid[1] !== 1'b1 || a.out_data[15:8] !== 8'h66 || a.out_src[3:2] !== 2'd3) begin
      errors++;
      $display("FAIL bp_release_out valid1=%b data1=%h src1=%0d want 1/66/3", a.out_valid[1], a.out_data[15:8], a.out_src[3:2]);
    end
    cycle();
  endtask

  task automatic test_bad_dest();
    b.out_ready = '1;
    b.in_valid[0] = 1'b1; b.in_dest[1:0] = 2'd3; b.in_data[7:0] = 8'hBD;
    #1;
    checks++;
    if (b.in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL bad_ready got=%b want 1", b.in_ready[0]);
    end
    cycle();
    b.in_valid = '0;
    checks++;
    if (b.out_valid !== 3'b000 || b.err_bad_dest !== 1'b1) begin
      errors++; $display("FAIL bad_pulse valid=%b err=%b want 000/1", b.out_valid, b.err_bad_dest);
    end
    b.in_valid[1] = 1'b1; b.in_dest[3:2] = 2'd2; b.in_data[15:8] = 8'h3C;
    #1;
    checks++;
    if (b.in_ready !== 4'b0010) begin
      errors++; $display("FAIL bad_legal_ready got=%b want 0010", b.in_ready);
    end
    cycle();
    b.in_valid = '0;
    checks++;
    if (b.err_bad_dest !== 1'b0 || b.out_valid !== 3'b100 || b.out_data[23:16] !== 8'h3C || b.out_src[5:4] !== 2'd1) begin
      errors++;
      $display("FAIL bad_legal_out err=%b valid=%b data2=%h src2=%0d want 0/100/3c/1", b.err_bad_dest, b.out_valid, b.out_data[23:16], b.out_src[5:4]);
    end
    cycle();
  endtask

  task automatic test_random();
    logic [NI-1:0] acc;
    logic [NO-1:0] ev;
    logic [NO*W-1:0] ed, dm;
    logic [NO*SW-1:0] es, sm;
    for (int i = 0; i < NI; i++) drive(i, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, NO - 1));
    a.out_ready = 4'($urandom);
    for (int n = 0; n < 400; n++) begin
      #1;
      model_eval();
      checks++;
      if (a.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rand_ready[%0d] got=%b want=%b", n, a.in_ready, exp_rdy);
      end
      acc = a.in_valid & exp_rdy;
      cycle();
      ev = '0; ed = '0; dm = '0; es = '0; sm = '0;
      for (int j = 0; j < NO; j++)
        if (mv[j]) begin
          ev[j] = 1'b1;
          ed[j*W +: W] = W'(md[j]); dm[j*W +: W] = '1;
          es[j*SW +: SW] = SW'(ms[j]); sm[j*SW +: SW] = '1;
        end
      checks++;
      if (a.out_valid !== ev || (a.out_data & dm) !== ed || (a.out_src & sm) !== es) begin
        errors++;
        $display("FAIL rand_out[%0d] valid=%b data=%h src=%h want %b/%h/%h", n, a.out_valid, a.out_data & dm, a.out_src & sm, ev, ed, es);
      end
      for (int i = 0; i < NI; i++)
        if (!a.in_valid[i] || acc[i]) drive(i, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, NO - 1));
      a.out_ready = 4'($urandom);
    end
    idle();
    a.out_ready = '1;
    cycle();
  endtask

  task automatic test_reset_mid();
    a.out_ready = '1;
    for (int i = 0; i < NI; i++) drive(i, 1, 'h30 + i, i);
    cycle();
    idle();
    a.out_ready = '0;
    checks++;
    if (a.out_valid !== 4'hF) begin
      errors++; $display("FAIL mid_fill valid=%b want 1111", a.out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (a.out_valid !== '0 || a.out_data !== '0) begin
      errors++; $display("FAIL mid_reset valid=%b data=%h want 0/0", a.out_valid, a.out_data);
    end
    a.out_ready = '1;
    for (int i = 0; i < NI; i++) drive(i, 1, 'h40 + i, 0);
    #1;
    checks++;
    if (a.in_ready !== 4'b0001) begin
      errors++; $display("FAIL mid_first_ready got=%b want 0001", a.in_ready);
    end
    cycle();
    idle();
    checks++;
    if (a.out_valid[0] !== 1'b1 || a.out_src[1:0] !== 2'd0 || a.out_data[7:0] !== 8'h40) begin
      errors++;
      $display("FAIL mid_first_out valid0=%b src0=%0d data0=%h want 1/0/40", a.out_valid[0], a.out_src[1:0], a.out_data[7:0]);
    end
    cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    a.in_valid = '0; a.in_data = '0; a.in_dest = '0; a.out_ready = '0;
    b.in_valid = '0; b.in_data = '0; b.in_dest = '0; b.out_ready = '0;
    test_reset();
    test_single();
    test_parallel();
    test_round_robin();
    test_backpressure();
    test_bad_dest();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_crossbar.md
Name: stream_crossbar

Overview:
Parametrised NUM_IN x NUM_OUT crossbar switch with valid/ready streams. It is the successor to the combinational 2x2 swap crossbar.
Each input beat carries a destination index. Each output port has a round-robin arbiter and one registered output stage.
It routes operand and request streams between producer and consumer units, for example issue ports to functional units or LSU to memory banks.

Parameters:
NUM_IN, 4, number of input ports (>=2)
NUM_OUT, 4, number of output ports (>=2)
WIDTH, 32, payload width in bits
DEST_W, $clog2(NUM_OUT), destination index width (derived; do not override)
SRC_W, $clog2(NUM_IN), source index width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  NUM_IN  per-input beat valid
in_data  input  NUM_IN*WIDTH  packed payloads; input i occupies bits [i*WIDTH +: WIDTH]
in_dest  input  NUM_IN*DEST_W  packed destination index per input
in_ready  output  NUM_IN  per-input accept, combinational
out_valid  output  NUM_OUT  per-output beat valid, registered
out_data  output  NUM_OUT*WIDTH  packed registered payloads
out_src  output  NUM_OUT*SRC_W  input index that produced the beat, registered
out_ready  input  NUM_OUT  per-output consumer accept
err_bad_dest  output  1  registered one-cycle pulse: at least one beat was discarded for an out-of-range in_dest

Behaviour:
- Reset, with rst high at an edge:
  - out_valid=0, out_data=0, out_src=0, err_bad_dest=0.
  - All round-robin pointers = 0.
  - A reset mid-transfer discards held beats. Nothing is replayed.
  - in_ready is still computed combinationally during rst but is ignored; the bench must hold in_valid=0 during rst.
- Handshake:
  - A transfer happens when valid&&ready are both high at a clock edge.
  - Producers must not make in_valid depend on in_ready.
  - in_valid/in_data/in_dest are held stable until accepted.
- Per output j:
  - load_en[j] = !out_valid[j] || out_ready[j].
  - req[j][i] = in_valid[i] && (in_dest[i]==j).
  - If load_en[j] and any req[j] is set, the arbiter grants exactly one input: the first set request scanning i = ptr[j], ptr[j]+1, ... modulo NUM_IN.
- On a grant to input g at output j:
  - in_ready[g]=1.
  - Next edge: out_valid[j]=1, out_data[j]=in_data[g], out_src[j]=g.
  - ptr[j] = (g+1) mod NUM_IN.
- With load_en[j] high and no request: out_valid[j] becomes 0 at the next edge, and ptr[j] holds.
- With load_en[j] low (stalled): the output register and ptr[j] hold, and no input targeting j gets in_ready.
- Latency and throughput:
  - Latency is 1 cycle from input accept to out_valid.
  - Full throughput: one beat per output per cycle, including while out_ready stays high.
- Concurrency:
  - Inputs targeting different outputs are accepted in the same cycle, with no interaction.
  - At most one beat per output per cycle.
- Bad destination (in_dest >= NUM_OUT, possible only when NUM_OUT is not a power of two):
  - in_ready[i]=1 unconditionally and the beat is dropped.
  - err_bad_dest=1 on the next cycle, for one cycle per offending cycle.
- Fairness: with all NUM_IN inputs continuously requesting the same unstalled output, each input is granted exactly once in every NUM_IN consecutive grants.
- Pointer wrap: when g = NUM_IN-1, ptr wraps to 0.

Decomposition:
- Package stream_crossbar_pkg: helper function clog2_min1(n), which returns max(1,$clog2(n)) and is used for DEST_W and SRC_W so that 1-bit indices stay legal.
- Sub-module rr_arbiter #(N):
  - Inputs: req[N], ptr.
  - Outputs: one-hot grant, grant_idx, any.
  - Purely combinational. Instantiated once per output.
  - The parent owns the pointer registers.

Test Plan:
1. Reset then one beat (NUM_IN=NUM_OUT=4, WIDTH=8): after rst, input 2 sends 0xA5 to dest 1 with out_ready=1 -> in_ready[2]=1 that cycle; next cycle out_valid[1]=1, out_data[1]=0xA5, out_src[1]=2; all other out_valid=0.
2. Parallel routing: inputs 0..3 send 0x10,0x11,0x12,0x13 to dests 3,2,1,0 in the same cycle -> all in_ready=1; next cycle out_data = {0x13,0x12,0x11,0x10} on outputs 0..3 and out_src = {3,2,1,0}.
3. Round-robin contention: all 4 inputs hold dest 0 continuously, out_ready[0]=1 -> out_src[0] sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
4. Backpressure: out_ready[1]=0 for 3 cycles while out_valid[1]=1 with 0x55 -> out_data[1] stays 0x55, no in_ready for dest-1 inputs, ptr[1] unchanged; after out_ready[1] rises, the queued beat appears next cycle.
5. Bad destination (NUM_OUT=3): input 0 sends dest 3 -> in_ready[0]=1, no out_valid asserted, err_bad_dest=1 for exactly one cycle.
6. Reset mid-operation: assert rst while out_valid = 4'b1111 -> next cycle out_valid=0, out_data=0; then contention on dest 0 grants input 0 first, because pointers are reset.
